// File: rtl/scs8hd_clkdivinv_prog.sv
// scs8hd_clkdivinv_prog: programmable glitch-free clock divider with selectable output polarity.
// The divided clock comes straight from a register. Changes to the run/stop state and to the
// divide ratio take effect only on period boundaries, so the output never produces a runt pulse.
//
// Ports:
//   i_clk       source clock, rising edge active
//   i_resetb    asynchronous active-low reset
//   i_en        run request (level)
//   i_div       requested divide ratio, sampled when i_div_req is high
//   i_div_req   single-cycle strobe that captures i_div into the pending register
//   o_y         divided clock, polarity set by INVERT
//   o_tc        one-cycle pulse in the cycle after the counter wraps
//   o_div_ack   one-cycle pulse when a pending ratio becomes active
//   o_pend      a captured ratio is waiting for the next boundary
//   o_run       divider is not idle
module scs8hd_clkdivinv_prog #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned INVERT    = 1,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_resetb,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_div_req,
  output logic             o_y,
  output logic             o_tc,
  output logic             o_div_ack,
  output logic             o_pend,
  output logic             o_run
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStop
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_q;
  logic [WIDTH-1:0] r_div_cur;
  logic [WIDTH-1:0] r_div_pend;
  logic             r_pend;
  logic             r_tc;
  logic             r_div_ack;
  logic             r_run;

  logic [WIDTH-1:0] w_last;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_div_clamp;
  logic             w_wrap;
  logic             w_boundary;

  // Last count of the current period and length of the high phase.
  assign w_last      = r_div_cur - WIDTH'(1);
  assign w_half      = r_div_cur >> 1;
  assign w_wrap      = (r_state != StIdle) && (r_cnt == w_last);
  assign w_boundary  = (r_state == StIdle) || w_wrap;
  assign w_cnt_next  = w_wrap ? '0 : r_cnt + WIDTH'(1);
  // Ratios below 2 cannot form a high and a low phase, so they are raised to 2.
  assign w_div_clamp = (i_div < WIDTH'(2)) ? WIDTH'(2) : i_div;

  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_q        <= 1'b0;
      r_div_cur  <= WIDTH'(RESET_DIV);
      r_div_pend <= '0;
      r_pend     <= 1'b0;
      r_tc       <= 1'b0;
      r_div_ack  <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_tc      <= 1'b0;
      r_div_ack <= 1'b0;

      case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (i_en) begin
            r_state <= StRun;
            r_q     <= 1'b1;
            r_run   <= 1'b1;
          end else begin
            r_q <= 1'b0;
          end
        end
        StRun, StStop: begin
          r_tc <= w_wrap;
          if ((r_state == StStop) && !i_en && w_wrap) begin
            // Stop only after a complete period, leaving the output in its low phase.
            r_state <= StIdle;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_run   <= 1'b0;
          end else begin
            r_state <= i_en ? StRun : StStop;
            r_cnt   <= w_cnt_next;
            // On a wrap the count restarts at 0, which is high for any ratio >= 2,
            // so a ratio applied on this same edge cannot disturb this value.
            r_q     <= (w_cnt_next < w_half);
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
          r_q     <= 1'b0;
          r_run   <= 1'b0;
        end
      endcase

      if (w_boundary && r_pend) begin
        r_div_cur <= r_div_pend;
        r_div_ack <= 1'b1;
        r_pend    <= 1'b0;
      end
      // A new request on the same edge as an application is captured and stays pending.
      if (i_div_req) begin
        r_div_pend <= w_div_clamp;
        r_pend     <= 1'b1;
      end
    end
  end

  assign o_y       = (INVERT != 0) ? ~r_q : r_q;
  assign o_tc      = r_tc;
  assign o_div_ack = r_div_ack;
  assign o_pend    = r_pend;
  assign o_run     = r_run;

endmodule

// File: tb/tb_scs8hd_clkdivinv_prog.sv
module tb_scs8hd_clkdivinv_prog;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned INVERT = 1;
  localparam int unsigned RESET_DIV = 2;

  logic             clk = 1'b0;
  logic             i_resetb = 1'b0;
  logic             i_en = 1'b0;
  logic [WIDTH-1:0] i_div = '0;
  logic             i_div_req = 1'b0;
  logic             o_y, o_tc, o_div_ack, o_pend, o_run;

  int total = 0;
  int bad = 0;

  scs8hd_clkdivinv_prog #(
    .WIDTH    (WIDTH),
    .INVERT   (INVERT),
    .RESET_DIV(RESET_DIV)
  ) dut (
    .i_clk    (clk),
    .i_resetb (i_resetb),
    .i_en     (i_en),
    .i_div    (i_div),
    .i_div_req(i_div_req),
    .o_y      (o_y),
    .o_tc     (o_tc),
    .o_div_ack(o_div_ack),
    .o_pend   (o_pend),
    .o_run    (o_run)
  );

  always #5 clk = ~clk;

  // Reference model: the divider as a position within a period of n cycles.
  // Output is high for the first n/2 positions while running.
  int   m_n = RESET_DIV;
  int   m_pos = 0;
  int   m_pend_val = 0;
  bit   m_running = 1'b0;
  bit   m_stopping = 1'b0;
  bit   m_pend = 1'b0;
  bit   m_tc = 1'b0;
  bit   m_ack = 1'b0;
  bit   m_end;
  bit   m_bound;
  bit   m_y;
  logic [4:0] exp_q[$];
  logic [4:0] reset_vec;

  assign reset_vec = {INVERT[0], 4'b0000};

  always @(posedge clk or negedge i_resetb) begin
    if (!i_resetb) begin
      m_n = RESET_DIV; m_pos = 0; m_pend_val = 0;
      m_running = 0; m_stopping = 0; m_pend = 0; m_tc = 0; m_ack = 0;
      exp_q.delete();
    end else begin
      m_end   = m_running && (m_pos == m_n - 1);
      m_bound = !m_running || m_end;
      m_tc    = m_end;
      m_ack   = 1'b0;
      if (!m_running) begin
        m_pos = 0;
        if (i_en) begin
          m_running  = 1'b1;
          m_stopping = 1'b0;
        end
      end else if (m_stopping && !i_en && m_end) begin
        m_running = 1'b0;
        m_pos     = 0;
      end else begin
        m_pos      = m_end ? 0 : m_pos + 1;
        m_stopping = !i_en;
      end
      if (m_bound && m_pend) begin
        m_n    = m_pend_val;
        m_ack  = 1'b1;
        m_pend = 1'b0;
      end
      if (i_div_req) begin
        m_pend_val = (i_div < 2) ? 2 : int'(i_div);
        m_pend     = 1'b1;
      end
      m_y = (m_running && (m_pos < m_n / 2)) ^ INVERT[0];
      exp_q.push_back({m_y, m_tc, m_ack, m_pend, m_running});
    end
  end

  // Monitor: compares outputs each cycle against the scoreboard.
  logic [4:0] act;
  logic [4:0] expv;
  assign act = {o_y, o_tc, o_div_ack, o_pend, o_run};

  always @(negedge clk) begin
    if (!i_resetb) begin
      total++;
      if (act !== reset_vec) begin
        bad++;
        $display("FAIL reset_hold t=%0t got y,tc,ack,pend,run=%b want %b", $time, act, reset_vec);
      end
    end else if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      total++;
      if (act !== expv) begin
        bad++;
        $display("FAIL cycle t=%0t got y,tc,ack,pend,run=%b want %b", $time, act, expv);
      end
    end
  end

  task automatic cyc(input logic en, input logic [WIDTH-1:0] div, input logic req);
    i_en = en;
    i_div = div;
    i_div_req = req;
    @(negedge clk);
  endtask

  // Idle cycles with the given run level until the next edge sees position tgt.
  task automatic wait_pos(input int tgt, input logic en);
    int n;
    n = 0;
    while (!(m_running && m_pos == tgt) && n < 40) begin
      cyc(en, '0, 1'b0);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL wait_pos timeout got pos=%0d want %0d", m_pos, tgt);
    end
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #2;
    i_resetb = 1'b0;
    #1;
    total++;
    if (act !== reset_vec) begin
      bad++;
      $display("FAIL async_reset got y,tc,ack,pend,run=%b want %b", act, reset_vec);
    end
    @(negedge clk);
    repeat (3) cyc(1'b1, '0, 1'b0);
    i_resetb = 1'b1;
  endtask

  initial begin
    // Reset held while EN is high: outputs stay at reset values.
    repeat (2) cyc(1'b0, '0, 1'b0);
    repeat (5) cyc(1'b1, '0, 1'b0);
    i_resetb = 1'b1;
    // Default ratio 2.
    repeat (10) cyc(1'b1, '0, 1'b0);
    // Ratio change to 5.
    cyc(1'b1, 4'd5, 1'b1);
    repeat (20) cyc(1'b1, '0, 1'b0);
    // Clamp and override: 7 then 0 before the boundary, ending at ratio 2.
    wait_pos(0, 1'b1);
    cyc(1'b1, 4'd7, 1'b1);
    cyc(1'b1, 4'd0, 1'b1);
    repeat (12) cyc(1'b1, '0, 1'b0);
    // Stop and restart at ratio 6.
    cyc(1'b1, 4'd6, 1'b1);
    repeat (14) cyc(1'b1, '0, 1'b0);
    wait_pos(1, 1'b1);
    repeat (10) cyc(1'b0, '0, 1'b0);
    repeat (8) cyc(1'b1, '0, 1'b0);
    wait_pos(2, 1'b1);
    cyc(1'b0, '0, 1'b0);
    wait_pos(3, 1'b0);
    repeat (14) cyc(1'b1, '0, 1'b0);
    // Simultaneous: 4 pending, 3 requested on the boundary edge.
    wait_pos(0, 1'b1);
    cyc(1'b1, 4'd4, 1'b1);
    wait_pos(5, 1'b1);
    cyc(1'b1, 4'd3, 1'b1);
    repeat (14) cyc(1'b1, '0, 1'b0);
    // Async reset in the middle of a run.
    async_reset_check();
    repeat (6) cyc(1'b1, '0, 1'b0);
    // Random traffic.
    for (int i = 0; i < 1200; i++) begin
      logic en_r;
      logic req_r;
      en_r  = ($urandom_range(0, 9) == 0) ? ~i_en : i_en;
      req_r = ($urandom_range(0, 6) == 0);
      cyc(en_r, WIDTH'($urandom_range(0, 15)), req_r);
      if (i == 600) async_reset_check();
    end
    repeat (3) cyc(1'b0, '0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scs8hd_clkdivinv_prog.md
Name: scs8hd_clkdivinv_prog

Overview:
- Programmable, glitch-free clock divider with selectable output polarity.
- Next generation of the clock-inverter cell family: adds a parametrised divide ratio, run/stop gating, and a request/acknowledge ratio-update handshake.
- Sits at the root of local clock subtrees. It derives a slower, optionally inverted clock from CLK, which then feeds clkbuf/clkinv drivers.
- All state is on CLK rising edges. Output Y comes directly from a register, so it cannot glitch.

Parameters:
- WIDTH, 4: width of the DIV input and of the internal counter. Maximum ratio is 2^WIDTH-1.
- INVERT, 1: output polarity. 1 gives Y = ~q; 0 gives Y = q.
- RESET_DIV, 2: divide ratio loaded at reset. Must be in the range 2..2^WIDTH-1.

Ports:
- CLK  input  1  source clock; rising edge active
- RESETB  input  1  asynchronous, active-low reset
- EN  input  1  run request; level-sensitive
- DIV  input  WIDTH  requested divide ratio; sampled only on DIV_REQ
- DIV_REQ  input  1  single-cycle strobe that captures DIV into the pending register
- Y  output  1  divided clock (registered, with polarity applied per INVERT)
- TC  output  1  single-cycle pulse in the cycle after the counter wraps
- DIV_ACK  output  1  single-cycle pulse when a pending ratio becomes active
- PEND  output  1  a captured ratio is waiting for the next boundary
- RUN  output  1  state is not IDLE

Behaviour:
- Reset: RESETB low acts immediately, independent of CLK. It forces:
  - state=IDLE, cnt=0, q=0 (so Y=INVERT)
  - div_cur=RESET_DIV, div_pend=0
  - PEND=0, TC=0, DIV_ACK=0, RUN=0
  - Reset asserted mid-run truncates the current period with no further edges.
- Ratio clamp: any captured DIV value below 2 is stored as 2. With N=div_cur, the high phase is H=floor(N/2) cycles of q=1 and the low phase is N-H cycles.
- States:
  - IDLE, with EN=1: go to RUN; cnt<=0; q<=1.
  - IDLE, with EN=0: hold cnt=0, q=0.
  - RUN: cnt<=(cnt==N-1)?0:cnt+1; q<=(cnt_next<H). If EN=0, go to STOPPING (the count continues as in RUN).
  - STOPPING: counts as in RUN.
    - EN=1 returns to RUN with no gap or phase change.
    - At cnt==N-1 with EN=0: go to IDLE; cnt<=0; q<=0.
    - Result: Y stops only at the end of a full period, in the low phase, with no runt pulses.
- TC: registered 1 in the cycle after any edge where cnt wraps from N-1 to 0 in RUN or STOPPING. It also pulses on the STOPPING to IDLE transition.
- Boundary: a cycle is a boundary if it is in IDLE, or if it is in RUN/STOPPING with cnt==N-1.
- Update handshake:
  - DIV_REQ=1 at an edge: div_pend<=clamp(DIV); PEND<=1.
  - A later DIV_REQ before application overwrites div_pend (last wins).
  - At a boundary edge with PEND=1: div_cur<=div_pend; DIV_ACK<=1 for one cycle; PEND<=0. The new N governs the next period, starting at cnt=0.
  - DIV_REQ on the same edge as an application: the old pending value is applied and the new one is captured. PEND stays 1 and a second DIV_ACK follows at the next boundary.
  - In IDLE, a pending ratio is applied at the edge after capture.
- Latency:
  - EN rising, sampled at edge k: q=1 after edge k.
  - A ratio change is visible no later than one full current period after PEND rises.

Test Plan (WIDTH=4, INVERT=1, RESET_DIV=2):
- Reset: RESETB=0, then EN=1 for 5 cycles while RESETB stays 0 → Y=1, RUN=0, TC=0, PEND=0, DIV_ACK=0. Pull RESETB low mid-run → Y=1 immediately, with no clock edge needed.
- Default run: release reset, EN=1 → Y=0,1,0,1… changing every cycle. TC pulses every 2 cycles. RUN=1 one cycle after EN.
- Ratio change: DIV=5, DIV_REQ pulse while running → PEND=1 until the next wrap, then DIV_ACK one cycle. After that, Y is 0 for 2 cycles and 1 for 3 cycles, with TC every 5.
- Clamp and override: DIV=7 REQ, then DIV=0 REQ on the next cycle, both before a boundary → exactly one DIV_ACK. Active ratio is 2.
- Stop/restart: N=6, drop EN at cnt=1 → counting continues to cnt=5, then IDLE with Y=1 held and RUN=0. Second run: drop EN, then re-raise it at cnt=3 → no missing or extended period.
- Simultaneous events: DIV_REQ(DIV=3) on a boundary edge while PEND holds 4 → 4 is applied with DIV_ACK. PEND stays 1. 3 is applied one period later with a second DIV_ACK.
